// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter that shares one down-counter between NUM_REQ requesters.
// The winner's interval is loaded at grant, counted down to zero, and acknowledged by a one-cycle done pulse.
module counter_timer_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   len,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       busy,
   output logic [WIDTH-1:0]           count,
   output logic [NUM_REQ-1:0]         done
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e               state_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic                 busy_q;
   logic [WIDTH-1:0]     count_q;
   logic [NUM_REQ-1:0]   done_q;
   logic [IDX_W-1:0]     last_q;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [WIDTH-1:0]     win_len;
   logic [NUM_REQ-1:0]   win_oh;

   // Scan requesters starting just after the previous owner, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         int unsigned cand;
         cand = (32'(last_q) + k) % NUM_REQ;
         if (!win_found && req[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      win_len = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_len = len[i*WIDTH +: WIDTH];
         end
      end
      win_oh = NUM_REQ'(1) << win_idx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         done_q  <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_found) begin
                  grant_q <= win_oh;
                  busy_q  <= 1'b1;
                  last_q  <= win_idx;
                  count_q <= win_len;
                  // A zero-length job skips RUN and completes on the grant cycle itself.
                  if (win_len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= win_oh;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (!req[last_q]) begin
                  state_q <= ST_IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  count_q <= '0;
               end else if (count_q == WIDTH'(1)) begin
                  state_q <= ST_DONE;
                  count_q <= '0;
                  done_q  <= grant_q;
               end else begin
                  count_q <= count_q - WIDTH'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               done_q  <= '0;
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               count_q <= '0;
               done_q  <= '0;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign count = count_q;
   assign done  = done_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Directed bench for counter_timer_arbiter: vector table plus hand-written reset and max-length sequences.
module tb_counter_timer_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] len;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  count;
   logic [3:0]  done;

   int checks = 0;
   int errors = 0;

   counter_timer_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .busy  (busy),
      .count (count),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] len;
      logic [3:0]  grant;
      logic        busy;
      logic [7:0]  count;
      logic [3:0]  done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] l,
                               logic [3:0] g, logic b, logic [7:0] c, logic [3:0] d);
      vec_t v;
      v.rst = r; v.req = q; v.len = l;
      v.grant = g; v.busy = b; v.count = c; v.done = d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                          input logic [7:0] c, input logic [3:0] d);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".done"},  32'(done),  32'(d));
   endtask

   task automatic step(input logic r, input logic [3:0] q, input logic [31:0] l);
      @(negedge clk);
      reset = r; req = q; len = l;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single job on requester 0, len0=3
      tbl.push_back(mk(0, 4'b0001, 32'h0000_0003, 4'b0001, 1, 8'd3, 4'b0000));
      tbl.push_back(mk(0, 4'b0001, 32'h0000_0003, 4'b0001, 1, 8'd2, 4'b0000));
      tbl.push_back(mk(0, 4'b0001, 32'h0000_0003, 4'b0001, 1, 8'd1, 4'b0000));
      tbl.push_back(mk(0, 4'b0001, 32'h0000_0003, 4'b0001, 1, 8'd0, 4'b0001));
      tbl.push_back(mk(0, 4'b0000, 32'h0000_0003, 4'b0000, 0, 8'd0, 4'b0000));
      // Zero length on requester 2
      tbl.push_back(mk(0, 4'b0100, 32'h0000_0000, 4'b0100, 1, 8'd0, 4'b0100));
      tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'd0, 4'b0000));
      tbl.push_back(mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'd0, 4'b0000));
      // Round-robin, all len=1
      for (int i = 0; i < 4; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << i;
         tbl.push_back(mk(0, 4'b1111, 32'h0101_0101, oh,      1, 8'd1, 4'b0000));
         tbl.push_back(mk(0, 4'b1111, 32'h0101_0101, oh,      1, 8'd0, oh));
         tbl.push_back(mk(0, 4'b1111, 32'h0101_0101, 4'b0000, 0, 8'd0, 4'b0000));
      end
      tbl.push_back(mk(0, 4'b1111, 32'h0101_0101, 4'b0001, 1, 8'd1, 4'b0000));
      tbl.push_back(mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'd0, 4'b0000));
      // Abort: req0 len=10 dropped after count=6, pending req1 len=2 follows
      tbl.push_back(mk(0, 4'b0011, 32'h0000_020A, 4'b0001, 1, 8'd10, 4'b0000));
      tbl.push_back(mk(0, 4'b0011, 32'h0000_020A, 4'b0001, 1, 8'd9,  4'b0000));
      tbl.push_back(mk(0, 4'b0011, 32'h0000_020A, 4'b0001, 1, 8'd8,  4'b0000));
      tbl.push_back(mk(0, 4'b0011, 32'h0000_020A, 4'b0001, 1, 8'd7,  4'b0000));
      tbl.push_back(mk(0, 4'b0011, 32'h0000_020A, 4'b0001, 1, 8'd6,  4'b0000));
      tbl.push_back(mk(0, 4'b0010, 32'h0000_020A, 4'b0000, 0, 8'd0,  4'b0000));
      tbl.push_back(mk(0, 4'b0010, 32'h0000_020A, 4'b0010, 1, 8'd2,  4'b0000));
      tbl.push_back(mk(0, 4'b0010, 32'h0000_020A, 4'b0010, 1, 8'd1,  4'b0000));
      tbl.push_back(mk(0, 4'b0010, 32'h0000_020A, 4'b0010, 1, 8'd0,  4'b0010));
      tbl.push_back(mk(0, 4'b0000, 32'h0000_020A, 4'b0000, 0, 8'd0,  4'b0000));
      tbl.push_back(mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'd0,  4'b0000));

      // Long reset with random requests
      reset = 1'b1;
      req   = 4'($urandom);
      len   = $urandom;
      #100;
      chk_all("reset_hold", 4'b0000, 0, 8'd0, 4'b0000);

      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(tbl[i].rst, tbl[i].req, tbl[i].len);
         chk_all(tag, tbl[i].grant, tbl[i].busy, tbl[i].count, tbl[i].done);
      end

      // Mid-run asynchronous reset: requester 1 running at count=5
      step(0, 4'b0010, 32'h0000_0500);
      chk_all("mid_grant", 4'b0010, 1, 8'd5, 4'b0000);
      #3;
      reset = 1'b1;
      #1;
      chk_all("async_rst", 4'b0000, 0, 8'd0, 4'b0000);
      step(0, 4'b1111, 32'h0303_0303);
      chk_all("post_rst_grant", 4'b0001, 1, 8'd3, 4'b0000);

      // Max length on requester 1
      step(1, 4'b0000, 32'h0000_0000);
      step(0, 4'b0010, 32'h0000_FF00);
      chk_all("max_grant", 4'b0010, 1, 8'd255, 4'b0000);
      for (int k = 1; k <= 254; k++) begin
         step(0, 4'b0010, 32'h0000_0000);
         chk("max_count", 32'(count), 32'(255 - k));
      end
      chk_all("max_last_run", 4'b0010, 1, 8'd1, 4'b0000);
      step(0, 4'b0010, 32'h0000_0000);
      chk_all("max_done", 4'b0010, 1, 8'd0, 4'b0010);
      step(0, 4'b0000, 32'h0000_0000);
      chk_all("max_idle", 4'b0000, 0, 8'd0, 4'b0000);
      step(0, 4'b0000, 32'h0000_0000);
      chk_all("max_no_underflow", 4'b0000, 0, 8'd0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
